// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types for the shared-adder arbiter.
// Widths, requester IDs, FSM states and the operand bundle.
package add_arb_pkg;

    localparam int ADD_W = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_AGU = 1'b1
    } req_id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
    } add_op_t;

    // Signed overflow: like-signed operands, result sign differs.
    function automatic logic ovf_of(
        input logic [ADD_W-1:0] a,
        input logic [ADD_W-1:0] b,
        input logic [ADD_W-1:0] s
    );
        return (a[ADD_W-1] == b[ADD_W-1]) &&
               (s[ADD_W-1] != a[ADD_W-1]);
    endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// add_arbiter_if: two requester ports plus the result port.
// rsp_ovf exists only when ADD_ARB_OVF_EN is defined.
interface add_arbiter_if;
    import add_arb_pkg::*;

    logic             req0_valid;
    logic [ADD_W-1:0] req0_a;
    logic [ADD_W-1:0] req0_b;
    logic             req0_cin;
    logic             req0_ready;

    logic             req1_valid;
    logic [ADD_W-1:0] req1_a;
    logic [ADD_W-1:0] req1_b;
    logic             req1_cin;
    logic             req1_ready;

    logic             rsp_valid;
    req_id_t          rsp_id;
    logic [ADD_W-1:0] rsp_sum;
    logic             rsp_cout;
`ifdef ADD_ARB_OVF_EN
    logic             rsp_ovf;
`endif
    logic             rsp_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
`ifdef ADD_ARB_OVF_EN
        input  rsp_ovf,
`endif
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
`ifdef ADD_ARB_OVF_EN
        output rsp_ovf,
`endif
        input  rsp_ready
    );

endinterface

// File: rtl/CLA_16bit.sv
// CLA_16bit: 16-bit two-level carry-lookahead adder.
// Four 4-bit lookahead groups under one group-level lookahead.
module CLA_16bit
    import add_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    // Flat sum-of-products carries for one 4-bit group.
    function automatic logic [4:0] cla4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0])
             | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [ADD_W-1:0] g;
    logic [ADD_W-1:0] p;
    logic [ADD_W-1:0] c;
    logic [3:0]       gg;
    logic [3:0]       gp;
    logic [4:0]       cg;
    logic [4:0]       blk;

    always_comb begin
        g   = a & b;
        p   = a ^ b;
        gg  = '0;
        gp  = '0;
        c   = '0;
        blk = '0;
        for (int k = 0; k < 4; k++) begin
            blk   = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            gg[k] = blk[4];
            gp[k] = &p[4*k +: 4];
        end
        cg = cla4(gg, gp, cin);
        for (int k = 0; k < 4; k++) begin
            blk          = cla4(g[4*k +: 4], p[4*k +: 4], cg[k]);
            c[4*k +: 4]  = blk[3:0];
        end
    end

    assign sum  = p ^ c;
    assign cout = cg[4];

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: round-robin share of one CLA between two requesters.
// Define ADD_ARB_OVF_EN to add the registered rsp_ovf output.
module add_arbiter
    import add_arb_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    add_arbiter_if.slave bus
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    req_id_t          last_q;
    req_id_t          gnt_id;
    logic             gnt0;
    logic             gnt1;
    logic             can_accept;
    logic             ready0;
    logic             ready1;
    logic             accept;
    add_op_t          op;
    logic [ADD_W-1:0] sum;
    logic             cout;
    logic [ADD_W-1:0] sum_q;
    logic             cout_q;
    req_id_t          id_q;

    assign can_accept = (state_q == EMPTY) | bus.rsp_ready;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt0 = bus.req0_valid &
               (~bus.req1_valid | (last_q == REQ_AGU));
        gnt1 = bus.req1_valid &
               (~bus.req0_valid | (last_q == REQ_ALU));
    end

    assign ready0 = rst_n & can_accept & gnt0;
    assign ready1 = rst_n & can_accept & gnt1;
    assign accept = ready0 | ready1;
    assign gnt_id = gnt1 ? REQ_AGU : REQ_ALU;

    always_comb begin
        op = '0;
        unique case (1'b1)
            gnt0: begin
                op.a   = bus.req0_a;
                op.b   = bus.req0_b;
                op.cin = bus.req0_cin;
            end
            gnt1: begin
                op.a   = bus.req1_a;
                op.b   = bus.req1_b;
                op.cin = bus.req1_cin;
            end
            default: ;
        endcase
    end

    CLA_16bit u_cla (
        .a    (op.a),
        .b    (op.b),
        .cin  (op.cin),
        .sum  (sum),
        .cout (cout)
    );

    // Drain and accept together keep the register FULL.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if (bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            last_q  <= REQ_AGU;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= gnt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= REQ_ALU;
        end else if (accept) begin
            sum_q  <= sum;
            cout_q <= cout;
            id_q   <= gnt_id;
        end
    end

`ifdef ADD_ARB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= ovf_of(op.a, op.b, sum);
        end
    end

    assign bus.rsp_ovf = ovf_q;
`endif

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_cout   = cout_q;

endmodule
